// File: rtl/i2c_burst_ctrl.sv
// I2C burst sequencer: drives the i2c_bit_shift byte engine through multi-byte write/read bursts.
// Optional device-address retry is compiled in with `define I2C_RETRY_EN.
module i2c_burst_ctrl #(
  parameter int unsigned ADDR_BYTES_MAX = 2,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned LEN_W          = 5,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        start,
  input  logic                        rw,
  input  logic [7:0]                  device_id,
  input  logic [8*ADDR_BYTES_MAX-1:0] reg_addr,
  input  logic [2:0]                  addr_bytes,
  input  logic [LEN_W-1:0]            len,
  input  logic [31:0]                 dly_cnt_max,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic                        rd_last,
  output logic                        busy,
  output logic                        done,
  output logic                        nack_err,
  output logic [5:0]                  eng_cmd,
  output logic                        eng_go,
  output logic [7:0]                  eng_tx,
  input  logic [7:0]                  eng_rx,
  input  logic                        eng_done,
  input  logic                        eng_ack
);

  localparam int unsigned AW = 8 * ADDR_BYTES_MAX;
  localparam int unsigned CW = (LEN_W > 3) ? LEN_W : 3;
  localparam logic [5:0] CmdWr   = 6'b000001;
  localparam logic [5:0] CmdSta  = 6'b000010;
  localparam logic [5:0] CmdRd   = 6'b000100;
  localparam logic [5:0] CmdSto  = 6'b001000;
  localparam logic [5:0] CmdAck  = 6'b010000;
  localparam logic [5:0] CmdNack = 6'b100000;

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StWrFetch, StAbort, StWaitAbort, StDly, StDone
  } state_e;
  typedef enum logic [1:0] {PhDev, PhAddr, PhDev2, PhData} phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     dly_q, dly_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            nack_q, nack_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;

  logic            rw_q;
  logic [7:0]      dev_q;
  logic [AW-1:0]   addr_q;
  logic [CW-1:0]   nab_q, len_q;
  logic [31:0]     dly_max_q;

  logic [CW-1:0]   nab_in, len_in, nab_last, len_last, addr_idx;
  logic [7:0]      addr_byte, byte_tx;
  logic [5:0]      byte_cmd;
  logic            byte_sto, byte_rd, accept, go_end, finish;

`ifdef I2C_RETRY_EN
  logic [7:0]      retry_cnt_q, retry_cnt_d;
  logic            retry_pend_q, retry_pend_d;
  logic            first_dev;
  assign first_dev = (phase_q == PhDev) || ((phase_q == PhDev2) && (nab_q == '0));
`else
  logic            unused_retry;
  assign unused_retry = ^RETRY_MAX;
`endif

  // Oversized requests clamp here so the byte counters can never wrap.
  assign nab_in   = (32'(addr_bytes) > ADDR_BYTES_MAX) ? CW'(ADDR_BYTES_MAX) : CW'(addr_bytes);
  assign len_in   = (32'(len) > MAX_BURST) ? CW'(MAX_BURST) : CW'(len);
  assign nab_last = nab_q - CW'(1);
  assign len_last = len_q - CW'(1);
  assign addr_idx = nab_last - cnt_q;
  assign addr_byte = 8'(addr_q >> {addr_idx, 3'b000});
  assign accept   = (state_q == StIdle) && start;

  always_comb begin
    byte_sto = 1'b0;
    byte_tx  = '0;
    byte_cmd = '0;
    byte_rd  = 1'b0;
    unique case (phase_q)
      PhDev: begin
        byte_sto = !rw_q && (nab_q == '0) && (len_q == '0);
        byte_tx  = dev_q;
        byte_cmd = CmdSta | CmdWr | (byte_sto ? CmdSto : 6'b0);
      end
      PhAddr: begin
        byte_sto = !rw_q && (cnt_q == nab_last) && (len_q == '0);
        byte_tx  = addr_byte;
        byte_cmd = CmdWr | (byte_sto ? CmdSto : 6'b0);
      end
      PhDev2: begin
        byte_tx  = dev_q | 8'h01;
        byte_cmd = CmdSta | CmdWr;
      end
      PhData: begin
        byte_sto = (cnt_q == len_last);
        byte_rd  = rw_q;
        byte_tx  = rw_q ? 8'h00 : wdata_q;
        if (rw_q) byte_cmd = CmdRd | (byte_sto ? (CmdNack | CmdSto) : CmdAck);
        else      byte_cmd = CmdWr | (byte_sto ? CmdSto : 6'b0);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    wdata_d    = wdata_q;
    nack_d     = nack_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    go_end     = 1'b0;
    finish     = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    eng_go     = 1'b0;
    eng_cmd    = '0;
    eng_tx     = '0;
    busy       = (state_q != StIdle) && (state_q != StDone);
`ifdef I2C_RETRY_EN
    retry_cnt_d  = retry_cnt_q;
    retry_pend_d = retry_pend_q;
`endif
    unique case (state_q)
      StIdle: if (start) begin
        nack_d  = 1'b0;
        cnt_d   = '0;
        phase_d = (rw && (nab_in == '0)) ? PhDev2 : PhDev;
        dly_d   = '0;
`ifdef I2C_RETRY_EN
        retry_cnt_d  = '0;
        retry_pend_d = 1'b0;
`endif
        if (rw && (len_in == '0)) state_d = (dly_cnt_max == '0) ? StDone : StDly;
        else                      state_d = StIssue;
      end
      StIssue: begin
        eng_go  = 1'b1;
        eng_cmd = byte_cmd;
        eng_tx  = byte_tx;
        state_d = StWait;
      end
      StWait: if (eng_done) begin
        if (byte_rd) begin
          rd_data_d  = eng_rx;
          rd_valid_d = 1'b1;
          rd_last_d  = byte_sto;
        end
        if (!byte_rd && eng_ack) begin
`ifdef I2C_RETRY_EN
          if (first_dev && (32'(retry_cnt_q) < RETRY_MAX)) begin
            retry_cnt_d  = retry_cnt_q + 8'd1;
            retry_pend_d = 1'b1;
          end else begin
            nack_d = 1'b1;
          end
`else
          nack_d = 1'b1;
`endif
          if (byte_sto) go_end = 1'b1;
          else          state_d = StAbort;
        end else if (byte_sto) begin
          go_end = 1'b1;
        end else begin
          unique case (phase_q)
            PhDev: begin
              cnt_d = '0;
              if (nab_q != '0) begin
                phase_d = PhAddr;
                state_d = StIssue;
              end else begin
                phase_d = PhData;
                state_d = StWrFetch;
              end
            end
            PhAddr: begin
              if (cnt_q != nab_last) begin
                cnt_d   = cnt_q + CW'(1);
                state_d = StIssue;
              end else if (rw_q) begin
                phase_d = PhDev2;
                state_d = StIssue;
              end else begin
                cnt_d   = '0;
                phase_d = PhData;
                state_d = StWrFetch;
              end
            end
            PhDev2: begin
              cnt_d   = '0;
              phase_d = PhData;
              state_d = StIssue;
            end
            PhData: begin
              cnt_d   = cnt_q + CW'(1);
              state_d = rw_q ? StIssue : StWrFetch;
            end
          endcase
        end
      end
      StWrFetch: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wdata_d = wr_data;
          state_d = StIssue;
        end
      end
      StAbort: begin
        eng_go  = 1'b1;
        eng_cmd = CmdSto;
        state_d = StWaitAbort;
      end
      StWaitAbort: if (eng_done) go_end = 1'b1;
      StDly: begin
        dly_d = dly_q + 32'd1;
        if (dly_q + 32'd1 == dly_max_q) finish = 1'b1;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
    endcase

    if (go_end) begin
      if (dly_max_q == '0) begin
        finish = 1'b1;
      end else begin
        state_d = StDly;
        dly_d   = '0;
      end
    end
    if (finish) begin
      state_d = StDone;
`ifdef I2C_RETRY_EN
      // A pending retry replays the whole transaction instead of completing.
      if (retry_pend_q) begin
        state_d      = StIssue;
        phase_d      = (rw_q && (nab_q == '0)) ? PhDev2 : PhDev;
        cnt_d        = '0;
        retry_pend_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      phase_q    <= PhDev;
      cnt_q      <= '0;
      dly_q      <= '0;
      wdata_q    <= '0;
      nack_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
`ifdef I2C_RETRY_EN
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      wdata_q    <= wdata_d;
      nack_q     <= nack_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
`ifdef I2C_RETRY_EN
      retry_cnt_q  <= retry_cnt_d;
      retry_pend_q <= retry_pend_d;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rw_q      <= 1'b0;
      dev_q     <= '0;
      addr_q    <= '0;
      nab_q     <= '0;
      len_q     <= '0;
      dly_max_q <= '0;
    end else if (accept) begin
      rw_q      <= rw;
      dev_q     <= device_id & 8'hFE;
      addr_q    <= reg_addr;
      nab_q     <= nab_in;
      len_q     <= len_in;
      dly_max_q <= dly_cnt_max;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign nack_err = nack_q;

endmodule

// File: doc/i2c_burst_ctrl.md
Name: i2c_burst_ctrl

Overview:
Parametrised I2C transaction sequencer that drives the team's i2c_bit_shift byte engine through its Cmd/Go/Trans_Done interface. It runs complete multi-byte write and read bursts with a 0..ADDR_BYTES_MAX-byte register address. Write data arrives on a valid/ready stream and read data leaves as a pulsed stream. Slave NACKs abort the burst cleanly. It sits between register-level masters (sensor init ROMs, host bridges) and the byte engine.

Parameters:
ADDR_BYTES_MAX, 2, maximum register-address bytes (1..4).
MAX_BURST, 16, maximum data bytes per transaction (1..256).
LEN_W, 5, width of len; must hold MAX_BURST (clog2(MAX_BURST+1)).
RETRY_MAX, 3, device-address retries; used only with I2C_RETRY_EN.

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
start  in  1  transaction request; accepted only when busy=0
rw  in  1  0=write, 1=read; latched on start
device_id  in  8  8-bit slave address; bit0 ignored and forced by the block
reg_addr  in  8*ADDR_BYTES_MAX  register address; low addr_bytes bytes used
addr_bytes  in  3  number of address bytes to send; values above ADDR_BYTES_MAX clamp
len  in  LEN_W  data byte count; values above MAX_BURST clamp
dly_cnt_max  in  32  idle cycles inserted after each transaction
wr_data  in  8  write stream data
wr_valid  in  1  write stream valid
wr_ready  out  1  write stream ready; byte taken when wr_valid&&wr_ready
rd_data  out  8  read byte
rd_valid  out  1  one-cycle pulse per read byte
rd_last  out  1  high with rd_valid on the final byte
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
nack_err  out  1  sticky NACK flag for the last transaction; cleared on next start
eng_cmd  out  6  engine command: WR=000001 STA=000010 RD=000100 STO=001000 ACK=010000 NACK=100000
eng_go  out  1  one-cycle engine start pulse
eng_tx  out  8  engine transmit byte
eng_rx  in  8  engine receive byte
eng_done  in  1  engine Trans_Done pulse
eng_ack  in  1  engine ack_o; 1 = slave NACKed

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-transfer drops eng_go and discards the transfer. Bus recovery is the engine's job.
- IDLE: on start with busy=0, latch all inputs, clear nack_err, set busy on the next cycle. start while busy is ignored.
- Each byte uses ISSUE (drive eng_cmd/eng_tx, eng_go=1 for one cycle) then WAIT (until eng_done). eng_go must never be high for two consecutive cycles.
- Write sequence:
  - DEV (STA|WR, device_id&FE).
  - addr_bytes address bytes, MSB first (WR).
  - len data bytes (WR).
  - The final byte of the sequence carries STO. With len=0 and addr_bytes=0 this is DEV with STA|WR|STO, i.e. an address probe.
- Write data fetch: before each data byte, enter WR_FETCH with wr_ready=1 and stay until the handshake. Stalling is unbounded and the engine stays idle. wr_ready is high only in WR_FETCH.
- Read sequence:
  - If addr_bytes>0: DEV write (STA|WR), then address bytes (WR).
  - Then DEV|01 (STA|WR).
  - Then len-1 bytes of RD|ACK and a last byte of RD|NACK|STO.
  - Read with len=0: no bus traffic, goes straight to DLY.
- Read output: on eng_done of each RD byte, rd_data<=eng_rx and rd_valid=1 on the next cycle. rd_last is set on byte len.
- NACK: eng_ack=1 on any write-phase byte (DEV, address, data, DEV|01) sets nack_err. If that byte did not carry STO, issue a STO-only command (ABORT, WAIT_ABORT); then go to DLY. Remaining write data is not fetched. eng_ack is ignored on RD bytes.
- DLY: count dly_cnt_max cycles (0 = none). Then done=1 for one cycle, busy=0 in the same cycle, return to IDLE. start is accepted from the cycle after done.
- Byte counters are internal, LEN_W wide and never wrap because clamping applies at latch time.

Optional Feature:
I2C_RETRY_EN:
- Defined: a NACK on the first DEV byte of a transaction issues STO, waits dly_cnt_max cycles, and restarts the whole transaction, up to RETRY_MAX times. nack_err is set only after the final retry fails. A NACK on any later byte aborts without retry.
- Undefined: any NACK aborts immediately as described in Behaviour.

Test Plan:
- Write, device_id=A0, addr_bytes=2, reg_addr=1234, len=3, data 11,22,33 -> eng_tx sequence A0,12,34,11,22,33; STO only on 33; three wr handshakes; done, nack_err=0.
- Read, device_id=A0, addr_bytes=1, reg_addr=05, len=4 -> A0(STA),05,A1(STA), then 3xRD|ACK and RD|NACK|STO; four rd_valid pulses; rd_last on the 4th.
- Read with addr_bytes=0, len=1 -> first command is A1 with STA|WR, then RD|NACK|STO; no write-address phase.
- NACK on address byte 2 of a write -> STO-only command follows, nack_err=1, no wr_ready; single done pulse.
- wr_valid held low 50 cycles during a len=2 write -> eng_go absent during the stall; transfer resumes after the handshake. start pulses while busy -> ignored.
- I2C_RETRY_EN, RETRY_MAX=3, slave NACKs DEV twice then ACKs -> 3 DEV attempts, transaction completes, nack_err=0.
